// File: rtl/prog_loader.sv
// Program loader: UART byte frames -> little-endian words into instruction memory.
// Optional trailing XOR checksum byte when PROG_LOADER_CHECKSUM_EN is defined.
module prog_loader #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_DATA = 3'd2,
`ifdef PROG_LOADER_CHECKSUM_EN
        S_FIN  = 3'd3,
`endif
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       count_q, count_d;
    logic [31:0]       word_q, word_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]   words_loaded_q, words_loaded_d;

    logic        idle_like;
    logic        launch;
    logic        hdr_done;
    logic [31:0] n_full;
    logic        n_zero;
    logic        n_over;
    logic        last_word;
    logic        data_acc;
    logic [31:0] word_next;

    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE)
                    || (state_q == S_ERR);
    assign launch    = idle_like && start;
    assign hdr_done  = (state_q == S_HDR) && rx_valid
                    && (byte_idx_q == 2'd3);
    assign n_full    = {rx_data, count_q[23:0]};
    assign n_zero    = (n_full == 32'd0);
    assign n_over    = ({1'b0, n_full} > (33'd1 << ADDR_W));
    // The write pulse of the final word is also the cycle the frame ends.
    assign last_word = (state_q == S_DATA) && mem_we_q
                    && ((32'(words_loaded_q) + 32'd1) == count_q);
    assign data_acc  = (state_q == S_DATA) && rx_valid && !last_word;
    assign word_next = {rx_data, word_q[31:8]};

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
    logic       csum_ok;

    assign csum_ok = (rx_data == csum_q);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_d = S_HDR;
            end
            S_HDR: begin
                if (hdr_done) begin
                    if (n_zero)      state_d = S_DONE;
                    else if (n_over) state_d = S_ERR;
                    else             state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    if (rx_valid) state_d = csum_ok ? S_DONE : S_ERR;
                    else          state_d = S_FIN;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_FIN: begin
                if (rx_valid) state_d = csum_ok ? S_DONE : S_ERR;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_hold = (state_q == S_HDR) || (state_q == S_DATA);
`ifdef PROG_LOADER_CHECKSUM_EN
        cpu_hold = cpu_hold || (state_q == S_FIN);
`endif
        done = (state_q == S_DONE);
        err  = (state_q == S_ERR);
    end

    always_comb begin
        byte_idx_d     = byte_idx_q;
        count_d        = count_q;
        word_d         = word_q;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        words_loaded_d = words_loaded_q;
        if (launch) begin
            byte_idx_d     = 2'd0;
            words_loaded_d = '0;
        end
        if (mem_we_q) begin
            words_loaded_d = words_loaded_q
                           + {{ADDR_W{1'b0}}, 1'b1};
        end
        if ((state_q == S_HDR) && rx_valid) begin
            count_d[8*byte_idx_q +: 8] = rx_data;
            byte_idx_d = byte_idx_q + 2'd1;
        end
        if (data_acc) begin
            word_d     = word_next;
            byte_idx_d = byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
                mem_we_d    = 1'b1;
                mem_wdata_d = word_next;
                mem_addr_d  = words_loaded_q[ADDR_W-1:0];
            end
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    always_comb begin
        csum_d = csum_q;
        if (launch)        csum_d = 8'd0;
        else if (data_acc) csum_d = csum_q ^ rx_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_q <= 8'd0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx_q     <= 2'd0;
            count_q        <= 32'd0;
            word_q         <= 32'd0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= 32'd0;
            words_loaded_q <= '0;
        end else begin
            byte_idx_q     <= byte_idx_d;
            count_q        <= count_d;
            word_q         <= word_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader with a 16-word memory (ADDR_W=4).
// Writes are checked by a monitor against expectations queued by stimulus.
module tb_prog_loader;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          err;
    logic [AW:0]   words_loaded;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            due;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [7:0] tb_csum;

    prog_loader #(.ADDR_W(AW)) dut (
        .clk(clk),
        .rst(rst_n),
        .start(start),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold),
        .done(done),
        .err(err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: addr %0h data %08h",
                         mem_addr, mem_wdata);
            end else begin
                e = sb.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data
                    || cyc != e.due) begin
                    n_fail++;
                    $display("FAIL write: got a=%0h d=%08h c=%0d exp a=%0h d=%08h c=%0d",
                             mem_addr, mem_wdata, cyc,
                             e.addr, e.data, e.due);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic byte_cycle(input logic v, input logic [7:0] b,
                              input logic s);
        rx_valid = v;
        rx_data  = b;
        start    = s;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) byte_cycle(1'b0, 8'h00, 1'b0);
    endtask

    task automatic pulse_start();
        tb_csum = 8'h00;
        byte_cycle(1'b0, 8'h00, 1'b1);
    endtask

    task automatic send_hdr(input logic [31:0] n);
        for (int i = 0; i < 4; i++) begin
            byte_cycle(1'b1, n[8*i +: 8], 1'b0);
        end
    endtask

    task automatic send_word(input logic [AW-1:0] a, input logic [31:0] w,
                             input int gap, input logic s_mid);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) sb.push_back('{a, w, cyc + 1});
            tb_csum = tb_csum ^ w[8*i +: 8];
            byte_cycle(1'b1, w[8*i +: 8], s_mid);
            idle(gap);
        end
    endtask

    task automatic finish_frame();
`ifdef PROG_LOADER_CHECKSUM_EN
        byte_cycle(1'b1, tb_csum, 1'b0);
`endif
        idle(2);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tb_csum  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", mem_we, 0);
        check("rst_hold", cpu_hold, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_wl", words_loaded, 0);
        rst_n = 1'b1;
        idle(2);
        check("idle_hold", cpu_hold, 0);

        // two-word frame with gaps between bytes
        pulse_start();
        check("a_hold_start", cpu_hold, 1);
        send_hdr(32'd2);
        check("a_hold_hdr", cpu_hold, 1);
        send_word(4'd0, 32'h00A00513, 2, 1'b0);
        send_word(4'd1, 32'h00100593, 1, 1'b0);
        finish_frame();
        check("a_done", done, 1);
        check("a_err", err, 0);
        check("a_hold_end", cpu_hold, 0);
        check("a_wl", words_loaded, 2);
        check("a_addr_hold", mem_addr, 1);
        check("a_wdata_hold", mem_wdata, 32'h00100593);

        // empty frame
        pulse_start();
        check("z_done_clr", done, 0);
        send_hdr(32'd0);
        check("z_done", done, 1);
        check("z_hold", cpu_hold, 0);
        check("z_wl", words_loaded, 0);

        // oversize frame: 17 words > 16
        pulse_start();
        send_hdr(32'd17);
        check("o_err", err, 1);
        check("o_done", done, 0);
        check("o_hold", cpu_hold, 0);
        check("o_wl", words_loaded, 0);

        // back-to-back bytes with start pulses mid-frame
        pulse_start();
        check("b_err_clr", err, 0);
        send_hdr(32'd1);
        send_word(4'd0, 32'h12345678, 0, 1'b1);
        finish_frame();
        check("b_done", done, 1);
        check("b_wl", words_loaded, 1);

        // full memory: 16 words back-to-back
        pulse_start();
        send_hdr(32'd16);
        for (int i = 0; i < 16; i++) begin
            send_word(AW'(i), 32'hC0DE0000 | (i * 32'h11), 0, 1'b0);
        end
        finish_frame();
        check("f_done", done, 1);
        check("f_err", err, 0);
        check("f_wl", words_loaded, 16);
        check("f_addr", mem_addr, 15);

        // bytes outside a frame are ignored
        byte_cycle(1'b1, 8'hAA, 1'b0);
        byte_cycle(1'b1, 8'h55, 1'b0);
        idle(2);
        check("i_wl", words_loaded, 16);
        check("i_done", done, 1);

        // reset in the middle of a data word
        pulse_start();
        send_hdr(32'd1);
        byte_cycle(1'b1, 8'hEF, 1'b0);
        byte_cycle(1'b1, 8'hBE, 1'b0);
        rst_n = 1'b0;
        #1;
        check("r_we", mem_we, 0);
        check("r_hold", cpu_hold, 0);
        check("r_done", done, 0);
        check("r_addr", mem_addr, 0);
        check("r_wdata", mem_wdata, 0);
        check("r_wl", words_loaded, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        pulse_start();
        send_hdr(32'd1);
        send_word(4'd0, 32'hDEADBEEF, 1, 1'b0);
        finish_frame();
        check("r2_done", done, 1);
        check("r2_wl", words_loaded, 1);

`ifdef PROG_LOADER_CHECKSUM_EN
        // good checksum arriving in the write cycle
        pulse_start();
        send_hdr(32'd1);
        send_word(4'd0, 32'h08040201, 0, 1'b0);
        byte_cycle(1'b1, 8'h0F, 1'b0);
        idle(2);
        check("c_done", done, 1);
        check("c_err", err, 0);

        // bad checksum after a pause
        pulse_start();
        send_hdr(32'd1);
        send_word(4'd0, 32'h08040201, 2, 1'b0);
        check("c_hold_fin", cpu_hold, 1);
        byte_cycle(1'b1, 8'h0E, 1'b0);
        idle(1);
        check("c_bad_err", err, 1);
        check("c_bad_done", done, 0);
        check("c_bad_wl", words_loaded, 1);
`endif

        idle(3);
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: timeout");
        $fatal(1);
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction memory that the fetch stage reads.
- Takes a byte stream from the board UART receiver, assembles little-endian 32-bit instruction words and writes them to program memory at consecutive word addresses starting at 0.
- Holds the CPU core in reset while loading.
- Frame format: 4-byte little-endian word count N, then N words (4 bytes each, LSB first).

Parameters:
- ADDR_W, 14, program memory word-address width; capacity is 2^ADDR_W words.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- start  in  1  single-cycle pulse that begins a load frame.
- rx_valid  in  1  single-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- mem_we  out  1  program memory write enable, one cycle per word.
- mem_addr  out  ADDR_W  word address for the write.
- mem_wdata  out  32  instruction word to write.
- cpu_hold  out  1  high while loading; drives core reset/stall.
- done  out  1  level, high after a successful frame until the next start.
- err  out  1  level, high after an aborted frame until the next start.
- words_loaded  out  ADDR_W+1  count of words written in the current or last frame.

Behaviour:
- Reset (asynchronous, rst=0) values:
  - State IDLE.
  - mem_we, cpu_hold, done and err are 0.
  - mem_addr, mem_wdata and words_loaded are 0.
  - Byte index is 0, count register is 0.
- States: IDLE, HDR, DATA, FIN (FIN only with the optional feature), DONE, ERR.
- IDLE/DONE/ERR:
  - rx_valid is ignored.
  - start moves to HDR.
  - On start: clear done, err, words_loaded and byte index; set cpu_hold=1 from the next cycle.
- HDR:
  - Each accepted byte goes into count[8*i+:8], i = 0..3.
  - After the 4th byte:
    - N=0: go to DONE.
    - N > 2^ADDR_W: go to ERR.
    - Otherwise: go to DATA.
- DATA:
  - Bytes shift into a word assembly register, LSB first.
  - On the cycle the 4th byte is accepted, the next rising edge asserts mem_we=1 for exactly one cycle, with:
    - mem_wdata = assembled word;
    - mem_addr = words_loaded[ADDR_W-1:0].
  - words_loaded increments in the same edge that drops mem_we.
  - Latency is 1 cycle from the 4th rx_valid to mem_we.
  - When words_loaded reaches N: go to DONE, or to FIN if the feature is enabled.
- rx_valid may arrive on back-to-back cycles; every strobe must be accepted with no drops.
- A byte arriving in the mem_we cycle is accepted normally.
- start while in HDR/DATA/FIN is ignored; the frame continues.
- DONE: done=1, cpu_hold=0. ERR: err=1, cpu_hold=0.
- Reset mid-frame aborts immediately: mem_we=0, no partial word is written, state returns to IDLE.
- mem_addr wraps are impossible because N ≤ 2^ADDR_W. The last address written is N-1.
- mem_wdata and mem_addr hold their last values when mem_we=0.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Enabled:
  - After the last data byte, state FIN expects one more byte equal to the XOR of all 4N data bytes.
  - Match goes to DONE; mismatch goes to ERR.
  - Words are still written as they arrive; only err/done reflect the result.
  - The checksum accumulator clears on start.
- Disabled:
  - No FIN state and no accumulator.
  - The transition after the last word goes straight to DONE.

Test Plan:
- Reset then start, bytes 02 00 00 00, 13 05 A0 00, 93 05 10 00 -> mem_we twice: addr 0 data 0x00A00513, addr 1 data 0x00100593; done=1, words_loaded=2, cpu_hold high only during the frame.
- Start, header 00 00 00 00 -> done=1 right after the 4th byte, mem_we never asserted.
- With ADDR_W=4, header 11 00 00 00 (17 words) -> err=1, done=0, no writes, cpu_hold=0.
- Back-to-back rx_valid for 1 word 78 56 34 12 -> mem_we one cycle later with 0x12345678; extra start pulses mid-frame are ignored.
- Pull rst low after 2 data bytes -> outputs return to reset values at once, no write; a new start plus a full frame loads correctly.
- With PROG_LOADER_CHECKSUM_EN, 1 word 01 02 04 08 then checksum 0F -> done=1; the same frame with checksum 0E -> err=1, word still written at addr 0.
